icache_dm_responder: RTL and testbench
======================================

Name: icache_dm_responder

Overview:
- Responder end of the instruction-cache request interface driven by the pre-IF stage (valid/uncache/tag/index/offset, addr_ok handshake).
- Direct-mapped, 128-set, 32-byte-line instruction cache. Returns one 32-bit instruction per accepted request with a data_ok pulse.
- On a miss or an uncached access, it fetches from memory through a simple burst read port.

Parameters:
- TAG_W, 20, physical tag width
- INDEX_W, 7, set index width (128 sets)
- OFFSET_W, 5, byte offset within the line (8 words per line)

Ports:
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- valid  input  1  fetch request valid
- uncache  input  1  1 = bypass the cache, single-word memory read
- tag  input  20  physical tag
- index  input  7  set index
- offset  input  5  byte offset; bits [1:0] are ignored
- addr_ok  output  1  request accepted this cycle (valid & addr_ok)
- data_ok  output  1  rdata valid for the oldest accepted request; one-cycle pulse
- rdata  output  32  instruction word
- rd_req  output  1  memory read request; held until rd_rdy
- rd_type  output  1  0 = single word, 1 = 8-word line burst
- rd_addr  output  32  word address (uncached) or line-aligned address (burst)
- rd_rdy  input  1  memory accepted rd_req
- ret_valid  input  1  return beat valid
- ret_last  input  1  final return beat
- ret_data  input  32  return beat data

Behaviour:
- Storage
  - Per set: valid bit, 20-bit tag, 8x32 data words.
  - Reset clears all 128 valid bits. Tag and data arrays are not reset.
- Request register: on accept, capture {uncache, tag, index, offset[4:2]}.
- FSM states: IDLE, LOOKUP, MISS, REFILL, RESP. Reset enters IDLE.
- IDLE
  - addr_ok = valid.
  - On accept, go to LOOKUP.
- LOOKUP (one cycle after accept)
  - hit = !req_uncache & valid[idx] & (tag_arr[idx] == req_tag).
  - On hit: data_ok = 1 and rdata = data[idx][word] in this cycle.
  - On hit, addr_ok = valid, so back-to-back hits sustain one instruction per cycle. If a new request is accepted, stay in LOOKUP with the new request; otherwise go to IDLE.
  - On miss or uncache: addr_ok = 0, go to MISS.
- MISS
  - rd_req = 1.
  - rd_type = !req_uncache.
  - rd_addr = uncache ? {tag,index,word,2'b00} : {tag,index,5'b0}.
  - Hold all rd_* outputs stable until rd_rdy. On rd_rdy, go to REFILL.
- REFILL
  - Count beats with a 3-bit counter starting at 0.
  - Cached access: each ret_valid beat writes data[idx][cnt]. Capture the beat where cnt == req_word as the response word.
  - Cached access, on ret_valid & ret_last: write tag_arr[idx] = req_tag, set valid[idx] = 1, go to RESP.
  - Uncached access: the single beat (ret_last = 1) is captured and nothing is written to the arrays. Go to RESP.
  - ret_last arriving before beat 7 on a cached burst is a protocol error. The line is still marked valid; this is a verification assertion.
- RESP
  - data_ok = 1, rdata = captured word. addr_ok = 0.
  - Go to IDLE.
- Outputs
  - addr_ok is 0 in MISS, REFILL and RESP.
  - data_ok is exactly one pulse per accepted request, in request order.
  - When data_ok = 0, rdata holds its previous value (don't-care for verification).
- Reset values: addr_ok 0, data_ok 0, rdata 0, rd_req 0, rd_type 0, rd_addr 0, beat counter 0.
- Reset mid-operation: FSM returns to IDLE and the outstanding request is dropped (no data_ok). A partially refilled line stays invalid because valid is set only on ret_last.
- Conflict miss: the refill overwrites the tag and all 8 words of the set.
- Simultaneous cases:
  - valid is sampled in LOOKUP only when hit. On a miss, the requester holds its request until addr_ok.
  - A request to the same set accepted in the same cycle as its refill completes (RESP) is impossible, because addr_ok = 0 in RESP.

Test Plan:
- Reset, then valid = 1, uncache = 0, tag = 0x1fc00, index = 0, offset = 0x04 → addr_ok next-cycle LOOKUP misses. rd_req with rd_type = 1 and rd_addr = 0x1fc00000. Return beats 0x100..0x107 → data_ok with rdata = 0x101; valid[0] = 1.
- Same line, offsets 0x00, 0x08, 0x1c issued back-to-back → three consecutive data_ok cycles with rdata 0x100, 0x102, 0x107, and no rd_req.
- uncache = 1, tag = 0x1fc00, index = 3, offset = 0x0c → rd_type = 0, rd_addr = 0x1fc0006c. Return single beat 0xdeadbeef with ret_last → data_ok with rdata = 0xdeadbeef. A following cached lookup to index 3 misses.
- Conflict: fill index 5 with tag 0x00001, then request tag 0x00002, index 5 → miss and refill. Re-requesting tag 0x00001 misses again.
- Delay rd_rdy by 4 cycles → rd_req, rd_type and rd_addr are held stable. Stall ret_valid between beats → the beat count is still correct and the right word is returned.
- Assert reset on beat 3 of a refill to index 9 → no data_ok, state IDLE. A later request to index 9 misses.

Source files
------------

// File: rtl/icache_dm_responder.sv
// icache_dm_responder: direct-mapped 128x32B instruction cache responder with burst refill port
// Ports: clk/reset (sync, active-high); valid/uncache/tag/index/offset request in, addr_ok accept;
// data_ok/rdata response; rd_req/rd_type/rd_addr/rd_rdy memory read request;
// ret_valid/ret_last/ret_data memory return beats.
`timescale 1ns/1ps
module icache_dm_responder #(
  parameter int TAG_W = 20,
  parameter int INDEX_W = 7,
  parameter int OFFSET_W = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic                uncache,
  input  logic [TAG_W-1:0]    tag,
  input  logic [INDEX_W-1:0]  index,
  input  logic [OFFSET_W-1:0] offset,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         rdata,
  output logic                rd_req,
  output logic                rd_type,
  output logic [31:0]         rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data
);
  localparam int SETS = 1 << INDEX_W;
  localparam int WW = OFFSET_W - 2;
  typedef enum logic [2:0] {IDLE, LOOKUP, MISS, REFILL, RESP} state_t;
  state_t state;
  logic req_unc;
  logic [TAG_W-1:0] req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [WW-1:0] req_word, cnt;
  logic [31:0] word_q, hit_word;
  logic [SETS-1:0] vbits;
  logic [TAG_W-1:0] tag_arr [SETS];
  logic [31:0] data_arr [SETS << WW];
  logic hit, accept, unused;
  assign unused = ^offset[1:0];
  assign hit = state == LOOKUP && !req_unc && vbits[req_idx] && tag_arr[req_idx] == req_tag;
  assign hit_word = data_arr[{req_idx, req_word}];
  assign addr_ok = valid && (state == IDLE || hit);
  assign accept = valid && addr_ok;
  assign data_ok = hit || state == RESP;
  // rdata keeps the last delivered word whenever no hit is being served
  assign rdata = hit ? hit_word : word_q;
  assign rd_req = state == MISS;
  assign rd_type = rd_req && !req_unc;
  assign rd_addr = !rd_req ? 32'd0 :
                   req_unc ? {req_tag, req_idx, req_word, 2'b00} : {req_tag, req_idx, {OFFSET_W{1'b0}}};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      vbits <= '0;
      cnt <= '0;
      word_q <= '0;
      req_unc <= 1'b0;
      req_tag <= '0;
      req_idx <= '0;
      req_word <= '0;
    end else begin
      if (accept) begin
        req_unc <= uncache;
        req_tag <= tag;
        req_idx <= index;
        req_word <= offset[OFFSET_W-1:2];
      end
      if (hit) word_q <= hit_word;
      case (state)
        IDLE: if (accept) state <= LOOKUP;
        LOOKUP: state <= hit ? (accept ? LOOKUP : IDLE) : MISS;
        MISS: if (rd_rdy) begin
          state <= REFILL;
          cnt <= '0;
        end
        REFILL: if (ret_valid) begin
          cnt <= cnt + 1'b1;
          if (req_unc || cnt == req_word) word_q <= ret_data;
          if (ret_last) begin
            state <= RESP;
            if (!req_unc) vbits[req_idx] <= 1'b1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // arrays carry no reset; only the valid bits gate their contents
  always_ff @(posedge clk) begin
    if (!reset && state == REFILL && ret_valid && !req_unc) begin
      data_arr[{req_idx, cnt}] <= ret_data;
      if (ret_last) tag_arr[req_idx] <= req_tag;
      if (ret_last) assert (cnt == '1);
    end
  end
endmodule

// File: tb/tb_icache_dm_responder.sv
// tb_icache_dm_responder: randomized and directed self-checking bench for icache_dm_responder
`timescale 1ns/1ps
module tb_icache_dm_responder;
  logic clk = 1'b0;
  logic reset, valid, uncache;
  logic [19:0] tag;
  logic [6:0] index;
  logic [4:0] offset;
  logic addr_ok, data_ok, rd_req, rd_type, rd_rdy, ret_valid, ret_last;
  logic [31:0] rdata, rd_addr, ret_data;
  int checks = 0, errors = 0;
  logic [31:0] mem_pre [logic [31:0]];
  bit mvalid [128];
  logic [19:0] mtag [128];
  always #5 clk = ~clk;
  icache_dm_responder dut (
    .clk(clk), .reset(reset), .valid(valid), .uncache(uncache), .tag(tag), .index(index),
    .offset(offset), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .rd_req(rd_req),
    .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy), .ret_valid(ret_valid),
    .ret_last(ret_last), .ret_data(ret_data)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return mem_pre.exists(a) ? mem_pre[a] : (a * 32'h9e3779b1) ^ 32'h13572468;
  endfunction
  function automatic logic [31:0] waddr(input logic [19:0] t, input logic [6:0] i, input logic [4:0] o);
    return {t, i, o[4:2], 2'b00};
  endfunction
  task automatic do_reset();
    reset = 1; valid = 0; uncache = 0; tag = 0; index = 0; offset = 0;
    rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    foreach (mvalid[k]) mvalid[k] = 0;
  endtask
  // Issues one request, plays memory (rd_rdy after dly cycles, up to stall idle cycles per beat)
  task automatic fetch(input logic u, input logic [19:0] t, input logic [6:0] i, input logic [4:0] o,
                       input int dly, input int stall, output logic [31:0] d, output bit missed,
                       output bit got, output logic ty, output logic [31:0] ad, output bit stable,
                       output int waits);
    got = 0; missed = 0; stable = 1; d = 'x; ty = 0; ad = 0; waits = 0;
    @(posedge clk);
    #1 valid = 1; uncache = u; tag = t; index = i; offset = o;
    @(negedge clk);
    while (!addr_ok && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!addr_ok) begin
      valid = 0;
      return;
    end
    @(posedge clk);
    #1 valid = 0;
    @(negedge clk);
    for (int c = 0; c < 300 && !got; c++) begin
      if (data_ok) begin
        d = rdata;
        got = 1;
      end else if (rd_req) begin
        missed = 1; ty = rd_type; ad = rd_addr;
        repeat (dly) begin
          @(negedge clk);
          if (!rd_req || rd_type !== ty || rd_addr !== ad) stable = 0;
        end
        rd_rdy = 1;
        @(negedge clk);
        rd_rdy = 0;
        for (int b = 0; b < (ty ? 8 : 1); b++) begin
          repeat ($urandom_range(0, stall)) @(negedge clk);
          ret_valid = 1; ret_last = (b == (ty ? 7 : 0)); ret_data = mem(ad + 32'(4 * b));
          @(negedge clk);
          ret_valid = 0; ret_last = 0;
        end
      end else @(negedge clk);
    end
  endtask
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 6;
    if (addr_ok !== 1'b0) begin errors++; $display("FAIL reset_addr_ok: got %b expected 0", addr_ok); end
    if (data_ok !== 1'b0) begin errors++; $display("FAIL reset_data_ok: got %b expected 0", data_ok); end
    if (rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
    if (rd_type !== 1'b0) begin errors++; $display("FAIL reset_rd_type: got %b expected 0", rd_type); end
    if (rd_addr !== 32'd0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 0", rd_addr); end
  endtask
  task automatic test_miss_fill();
    logic [31:0] d, ad; bit m, g, s; logic ty; int w;
    for (int k = 0; k < 8; k++) mem_pre[32'h1fc00000 + 32'(4 * k)] = 32'h100 + 32'(k);
    fetch(0, 20'h1fc00, 0, 5'h04, 0, 0, d, m, g, ty, ad, s, w);
    checks += 4;
    if (!m) begin errors++; $display("FAIL fill_miss: got no rd_req expected rd_req"); end
    if (ty !== 1'b1) begin errors++; $display("FAIL fill_rd_type: got %b expected 1", ty); end
    if (ad !== 32'h1fc00000) begin errors++; $display("FAIL fill_rd_addr: got %h expected 1fc00000", ad); end
    if (!g || d !== 32'h101) begin errors++; $display("FAIL fill_rdata: got %h (data_ok %b) expected 101", d, g); end
  endtask
  task automatic test_back_to_back();
    logic [4:0] offs [3] = '{5'h00, 5'h08, 5'h1c};
    logic [31:0] exp [3] = '{32'h100, 32'h102, 32'h107};
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      valid = 1; uncache = 0; tag = 20'h1fc00; index = 0; offset = offs[k];
      @(negedge clk);
      checks += 2;
      if (addr_ok !== 1'b1) begin errors++; $display("FAIL b2b_addr_ok%0d: got %b expected 1", k, addr_ok); end
      if (rd_req !== 1'b0) begin errors++; $display("FAIL b2b_rd_req%0d: got %b expected 0", k, rd_req); end
      if (k > 0) begin
        checks++;
        if (data_ok !== 1'b1 || rdata !== exp[k-1])
          begin errors++; $display("FAIL b2b_data%0d: got %b/%h expected 1/%h", k - 1, data_ok, rdata, exp[k-1]); end
      end
      @(posedge clk);
      #1;
    end
    valid = 0;
    @(negedge clk);
    checks++;
    if (data_ok !== 1'b1 || rdata !== exp[2])
      begin errors++; $display("FAIL b2b_data2: got %b/%h expected 1/%h", data_ok, rdata, exp[2]); end
  endtask
  task automatic test_uncached();
    logic [31:0] d, ad; bit m, g, s; logic ty; int w;
    mem_pre[32'h1fc0006c] = 32'hdeadbeef;
    fetch(1, 20'h1fc00, 3, 5'h0c, 0, 0, d, m, g, ty, ad, s, w);
    checks += 4;
    if (!m) begin errors++; $display("FAIL unc_miss: got no rd_req expected rd_req"); end
    if (ty !== 1'b0) begin errors++; $display("FAIL unc_rd_type: got %b expected 0", ty); end
    if (ad !== 32'h1fc0006c) begin errors++; $display("FAIL unc_rd_addr: got %h expected 1fc0006c", ad); end
    if (!g || d !== 32'hdeadbeef) begin errors++; $display("FAIL unc_rdata: got %h expected deadbeef", d); end
    fetch(0, 20'h1fc00, 3, 5'h0c, 0, 0, d, m, g, ty, ad, s, w);
    checks += 2;
    if (!m) begin errors++; $display("FAIL unc_then_cached_miss: got hit expected miss"); end
    if (!g || d !== 32'hdeadbeef) begin errors++; $display("FAIL unc_then_cached_rdata: got %h expected deadbeef", d); end
  endtask
  task automatic test_conflict();
    logic [31:0] d, ad; bit m, g, s; logic ty; int w;
    logic [19:0] ts [4] = '{20'h1, 20'h1, 20'h2, 20'h1};
    logic [4:0] os [4] = '{5'h00, 5'h08, 5'h04, 5'h10};
    bit em [4] = '{1, 0, 1, 1};
    for (int k = 0; k < 4; k++) begin
      fetch(0, ts[k], 5, os[k], 1, 1, d, m, g, ty, ad, s, w);
      checks += 2;
      if (m !== em[k]) begin errors++; $display("FAIL conflict_miss%0d: got %b expected %b", k, m, em[k]); end
      if (!g || d !== mem(waddr(ts[k], 5, os[k])))
        begin errors++; $display("FAIL conflict_rdata%0d: got %h expected %h", k, d, mem(waddr(ts[k], 5, os[k]))); end
    end
  endtask
  task automatic test_stall();
    logic [31:0] d, ad; bit m, g, s; logic ty; int w;
    fetch(0, 20'h777, 20, 5'h14, 4, 3, d, m, g, ty, ad, s, w);
    checks += 3;
    if (!s) begin errors++; $display("FAIL stall_hold: got unstable rd_* expected stable"); end
    if (ad !== {20'h777, 7'd20, 5'd0}) begin errors++; $display("FAIL stall_rd_addr: got %h expected %h", ad, {20'h777, 7'd20, 5'd0}); end
    if (!g || d !== mem(waddr(20'h777, 20, 5'h14)))
      begin errors++; $display("FAIL stall_rdata: got %h expected %h", d, mem(waddr(20'h777, 20, 5'h14))); end
  endtask
  task automatic test_reset_mid();
    logic [31:0] d, ad; bit m, g, s; logic ty; int w, seen;
    @(posedge clk);
    #1 valid = 1; uncache = 0; tag = 20'h123; index = 9; offset = 0;
    @(negedge clk);
    @(posedge clk);
    #1 valid = 0;
    repeat (2) @(negedge clk);
    rd_rdy = 1;
    @(negedge clk);
    rd_rdy = 0;
    for (int b = 0; b < 3; b++) begin
      ret_valid = 1; ret_data = mem({20'h123, 7'd9, 5'd0} + 32'(4 * b));
      @(negedge clk);
    end
    ret_data = 32'hbad0bad0;
    reset = 1;
    @(negedge clk);
    reset = 0; ret_valid = 0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (data_ok) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_no_data_ok: got %0d pulses expected 0", seen); end
    fetch(0, 20'h123, 9, 5'h04, 0, 0, d, m, g, ty, ad, s, w);
    checks += 3;
    if (w != 0) begin errors++; $display("FAIL midreset_idle: got %0d wait cycles expected 0", w); end
    if (!m) begin errors++; $display("FAIL midreset_miss: got hit expected miss"); end
    if (!g || d !== mem(waddr(20'h123, 9, 5'h04)))
      begin errors++; $display("FAIL midreset_rdata: got %h expected %h", d, mem(waddr(20'h123, 9, 5'h04))); end
  endtask
  task automatic test_random();
    logic [31:0] d, ad, ea; bit m, g, s, em; logic ty; int w;
    logic u; logic [19:0] t; logic [6:0] i; logic [4:0] o;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      u = ($urandom_range(0, 7) == 0); t = 20'($urandom_range(0, 2)); i = 7'($urandom_range(0, 7));
      o = 5'($urandom); ea = waddr(t, i, o);
      em = u || !mvalid[i] || mtag[i] != t;
      fetch(u, t, i, o, $urandom_range(0, 2), 2, d, m, g, ty, ad, s, w);
      checks += 2;
      if (m !== em) begin errors++; $display("FAIL rand_miss%0d: got %b expected %b", n, m, em); end
      if (!g || d !== mem(ea)) begin errors++; $display("FAIL rand_rdata%0d: got %h expected %h", n, d, mem(ea)); end
      if (m && em) begin
        checks += 2;
        if (ty !== !u) begin errors++; $display("FAIL rand_rd_type%0d: got %b expected %b", n, ty, !u); end
        if (ad !== (u ? ea : {ea[31:5], 5'd0}))
          begin errors++; $display("FAIL rand_rd_addr%0d: got %h expected %h", n, ad, u ? ea : {ea[31:5], 5'd0}); end
      end
      if (!u) begin mvalid[i] = 1; mtag[i] = t; end
    end
  endtask
  initial begin
    test_reset();
    test_miss_fill();
    test_back_to_back();
    test_uncached();
    test_conflict();
    test_stall();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
